// File: rtl/axi_lite_master_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite master user port between NUM_REQ
// local requesters, with a single read or write transaction outstanding at a time.
module axi_lite_master_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic [ID_WIDTH-1:0]              grant_id,
  output logic                             busy,
  output logic                             m_wr_req,
  output logic [ADDR_WIDTH-1:0]            m_wr_addr,
  output logic [DATA_WIDTH-1:0]            m_wr_data,
  output logic [DATA_WIDTH/8-1:0]          m_wr_strb,
  input  logic                             m_wr_done,
  input  logic [1:0]                       m_wr_resp,
  output logic                             m_rd_req,
  output logic [ADDR_WIDTH-1:0]            m_rd_addr,
  input  logic [DATA_WIDTH-1:0]            m_rd_data,
  input  logic                             m_rd_done,
  input  logic [1:0]                       m_rd_resp
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
  logic                   op_wr_q, op_wr_d;
  logic                   m_wr_req_q, m_wr_req_d;
  logic                   m_rd_req_q, m_rd_req_d;
  logic [ADDR_WIDTH-1:0]  m_wr_addr_q, m_wr_addr_d;
  logic [DATA_WIDTH-1:0]  m_wr_data_q, m_wr_data_d;
  logic [STRB_WIDTH-1:0]  m_wr_strb_q, m_wr_strb_d;
  logic [ADDR_WIDTH-1:0]  m_rd_addr_q, m_rd_addr_d;
  logic [NUM_REQ-1:0]     req_done_q, req_done_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]             rsp_resp_q, rsp_resp_d;

  logic                   win_found;
  logic [ID_WIDTH-1:0]    win_idx;
  logic                   win_write;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_data;
  logic [STRB_WIDTH-1:0]  win_strb;
  logic [NUM_REQ-1:0]     grant_onehot;
  int unsigned            cand;

  // Search starts one past the last grant and wraps, so the first hit is the round-robin winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_write = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    win_strb  = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_grant_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!win_found && (cand == j) && req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = ID_WIDTH'(j);
          win_write = req_write[j];
          win_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          win_data  = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
          win_strb  = req_wstrb[j*STRB_WIDTH +: STRB_WIDTH];
        end
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      grant_onehot[j] = (32'(grant_id_q) == j);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    op_wr_d      = op_wr_q;
    m_wr_req_d   = 1'b0;
    m_rd_req_d   = 1'b0;
    m_wr_addr_d  = m_wr_addr_q;
    m_wr_data_d  = m_wr_data_q;
    m_wr_strb_d  = m_wr_strb_q;
    m_rd_addr_d  = m_rd_addr_q;
    req_done_d   = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
          op_wr_d      = win_write;
          if (win_write) begin
            m_wr_addr_d = win_addr;
            m_wr_data_d = win_data;
            m_wr_strb_d = win_strb;
            m_wr_req_d  = 1'b1;
          end else begin
            m_rd_addr_d = win_addr;
            m_rd_req_d  = 1'b1;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Completions of the other transaction type are ignored.
        if (op_wr_q && m_wr_done) begin
          rsp_resp_d = m_wr_resp;
          req_done_d = grant_onehot;
          state_d    = S_DONE;
        end else if (!op_wr_q && m_rd_done) begin
          rsp_rdata_d = m_rd_data;
          rsp_resp_d  = m_rd_resp;
          req_done_d  = grant_onehot;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      grant_id_q   <= '0;
      op_wr_q      <= 1'b0;
      m_wr_req_q   <= 1'b0;
      m_rd_req_q   <= 1'b0;
      m_wr_addr_q  <= '0;
      m_wr_data_q  <= '0;
      m_wr_strb_q  <= '0;
      m_rd_addr_q  <= '0;
      req_done_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      op_wr_q      <= op_wr_d;
      m_wr_req_q   <= m_wr_req_d;
      m_rd_req_q   <= m_rd_req_d;
      m_wr_addr_q  <= m_wr_addr_d;
      m_wr_data_q  <= m_wr_data_d;
      m_wr_strb_q  <= m_wr_strb_d;
      m_rd_addr_q  <= m_rd_addr_d;
      req_done_q   <= req_done_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_id_q;
  assign req_done  = req_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign m_wr_req  = m_wr_req_q;
  assign m_wr_addr = m_wr_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign m_wr_strb = m_wr_strb_q;
  assign m_rd_req  = m_rd_req_q;
  assign m_rd_addr = m_rd_addr_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Bench for axi_lite_master_arbiter: a master/requester model checks each request
// pulse and completion against a queue of expected transactions in grant order.
module tb_axi_lite_master_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int SW = DW / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_wstrb;
  logic [NR-1:0]     req_done;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              m_wr_req;
  logic [AW-1:0]     m_wr_addr;
  logic [DW-1:0]     m_wr_data;
  logic [SW-1:0]     m_wr_strb;
  logic              m_wr_done;
  logic [1:0]        m_wr_resp;
  logic              m_rd_req;
  logic [AW-1:0]     m_rd_addr;
  logic [DW-1:0]     m_rd_data;
  logic              m_rd_done;
  logic [1:0]        m_rd_resp;

  axi_lite_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .grant_id(grant_id), .busy(busy),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_strb(m_wr_strb), .m_wr_done(m_wr_done), .m_wr_resp(m_wr_resp),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data),
    .m_rd_done(m_rd_done), .m_rd_resp(m_rd_resp)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  int          done_cyc = 0;
  bit          inject_spur = 1'b0;
  bit          spur_next = 1'b0;
  bit          spur_check = 1'b0;
  logic [31:0] exp_rdata = '0;

  // Master and requester model: answers each request after txn.lat idle WAIT cycles,
  // and drops the requester's req_valid when it sees req_done.
  initial begin
    txn_t t;
    m_wr_done = 1'b0; m_rd_done = 1'b0; m_wr_resp = '0; m_rd_resp = '0; m_rd_data = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      m_wr_done = 1'b0;
      m_rd_done = 1'b0;
      if (!aresetn) begin
        pend = 1'b0; spur_next = 1'b0; spur_check = 1'b0;
        exp_q.delete();
        exp_rdata = '0;
      end else begin
        if (spur_check) begin
          spur_check = 1'b0;
          total++;
          if (busy !== 1'b1 || req_done !== 4'b0000) begin
            bad++;
            $display("FAIL spurious_rd_done: busy=%b req_done=%b, required busy=1 req_done=0000",
                     busy, req_done);
          end
        end
        if (req_done !== 4'b0000) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: req_done=%b, required no completion", req_done);
          end else begin
            t = exp_q.pop_front();
            if (!t.wr) exp_rdata = t.rdata;
            if (req_done !== (4'b0001 << t.id) || rsp_resp !== t.resp ||
                rsp_rdata !== exp_rdata || grant_id !== IW'(t.id)) begin
              bad++;
              $display("FAIL done_req%0d: req_done=%b resp=%b rdata=%h gid=%0d, required %b %b %h %0d",
                       t.id, req_done, rsp_resp, rsp_rdata, grant_id,
                       4'b0001 << t.id, t.resp, exp_rdata, t.id);
            end
            total++;
            if (cyc - done_cyc != 1) begin
              bad++;
              $display("FAIL done_latency_req%0d: %0d cycles, required 1", t.id, cyc - done_cyc);
            end
            req_valid[t.id] = 1'b0;
          end
        end
        if (m_wr_req || m_rd_req) begin
          total++;
          if (pend || exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_request_pulse: wr_req=%b rd_req=%b, required none", m_wr_req, m_rd_req);
          end else begin
            cur = exp_q[0];
            if (m_wr_req !== cur.wr || m_rd_req !== !cur.wr || grant_id !== IW'(cur.id) ||
                (cur.wr ? (m_wr_addr !== cur.addr || m_wr_data !== cur.data || m_wr_strb !== cur.strb)
                        : (m_rd_addr !== cur.addr))) begin
              bad++;
              $display("FAIL issue_req%0d: wr=%b rd=%b gid=%0d waddr=%h wdata=%h strb=%h raddr=%h, required wr=%b id=%0d addr=%h data=%h strb=%h",
                       cur.id, m_wr_req, m_rd_req, grant_id, m_wr_addr, m_wr_data, m_wr_strb,
                       m_rd_addr, cur.wr, cur.id, cur.addr, cur.data, cur.strb);
            end
            pend = 1'b1;
            cnt = cur.lat;
            spur_next = inject_spur && cur.wr;
          end
        end else if (pend) begin
          total++;
          if (cur.wr ? (m_wr_addr !== cur.addr || m_wr_data !== cur.data || m_wr_strb !== cur.strb)
                     : (m_rd_addr !== cur.addr)) begin
            bad++;
            $display("FAIL hold_fields_req%0d: waddr=%h wdata=%h strb=%h raddr=%h, required addr=%h data=%h strb=%h",
                     cur.id, m_wr_addr, m_wr_data, m_wr_strb, m_rd_addr, cur.addr, cur.data, cur.strb);
          end
          if (spur_next) begin
            m_rd_done = 1'b1; m_rd_data = 32'hBAD0_BAD0; m_rd_resp = 2'b11;
            spur_next = 1'b0; spur_check = 1'b1;
          end
          if (cnt == 0) begin
            if (cur.wr) begin
              m_wr_done = 1'b1; m_wr_resp = cur.resp;
            end else begin
              m_rd_done = 1'b1; m_rd_data = cur.rdata; m_rd_resp = cur.resp;
            end
            done_cyc = cyc;
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic set_req(input int id, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    req_write[id] = wr;
    req_addr[id*AW +: AW] = addr;
    req_wdata[id*DW +: DW] = data;
    req_wstrb[id*SW +: SW] = strb;
    req_valid[id] = 1'b1;
  endtask

  task automatic push_exp(input int id, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [31:0] rdata, input logic [1:0] resp, input int lat);
    txn_t t;
    t.id = id; t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
    t.rdata = rdata; t.resp = resp; t.lat = lat;
    exp_q.push_back(t);
  endtask

  task automatic post(input int id, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] rdata, input logic [1:0] resp, input int lat);
    set_req(id, wr, addr, data, strb);
    push_exp(id, wr, addr, data, strb, rdata, resp, lat);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL %s_timeout: %0d transactions outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if ({req_done, rsp_rdata, rsp_resp, grant_id, busy, m_wr_req, m_wr_addr, m_wr_data,
         m_wr_strb, m_rd_req, m_rd_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b gid=%0d done=%b wr_req=%b rd_req=%b, required all zero",
               busy, grant_id, req_done, m_wr_req, m_rd_req);
    end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_all_four();
    @(negedge aclk);
    post(0, 1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, '0, 2'b00, 1);
    post(1, 1'b0, 32'h0000_0104, '0, '0, 32'hA5A5_0001, 2'b00, 0);
    post(2, 1'b1, 32'h0000_0108, 32'h2222_2222, 4'h3, '0, 2'b01, 3);
    post(3, 1'b0, 32'h0000_010C, '0, '0, 32'h5A5A_0003, 2'b00, 2);
    wait_drain("all_four");
  endtask

  task automatic test_single_write();
    @(negedge aclk);
    post(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, '0, 2'b00, 1);
    @(posedge aclk);
    #1;
    total++;
    if (m_wr_req !== 1'b1 || m_rd_req !== 1'b0 || m_wr_addr !== 32'h0000_0010 ||
        m_wr_data !== 32'hDEAD_BEEF || m_wr_strb !== 4'hF) begin
      bad++;
      $display("FAIL write_issue_latency: wr_req=%b rd_req=%b addr=%h data=%h strb=%h, required 1 0 00000010 deadbeef f",
               m_wr_req, m_rd_req, m_wr_addr, m_wr_data, m_wr_strb);
    end
    @(posedge aclk);
    #1;
    total++;
    if (m_wr_req !== 1'b0 || m_rd_req !== 1'b0) begin
      bad++;
      $display("FAIL write_pulse_width: wr_req=%b rd_req=%b, required 0 0", m_wr_req, m_rd_req);
    end
    wait_drain("single_write");
    @(posedge aclk);
    #1;
    total++;
    if (busy !== 1'b0 || rsp_resp !== 2'b00) begin
      bad++;
      $display("FAIL write_idle_after: busy=%b resp=%b, required 0 00", busy, rsp_resp);
    end
  endtask

  task automatic test_wrap();
    @(negedge aclk);
    post(1, 1'b0, 32'h0000_0200, '0, '0, 32'h0BAD_F00D, 2'b00, 0);
    wait_drain("wrap_setup");
    @(negedge aclk);
    post(0, 1'b1, 32'h0000_0300, 32'h3333_0000, 4'hC, '0, 2'b00, 1);
    post(1, 1'b0, 32'h0000_0204, '0, '0, 32'h4444_0001, 2'b00, 1);
    wait_drain("wrap");
  endtask

  task automatic test_read_slverr();
    @(negedge aclk);
    post(2, 1'b0, 32'h0000_0040, '0, '0, 32'h1234_5678, 2'b10, 2);
    wait_drain("read_slverr");
    total++;
    if (rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b10 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL read_slverr_hold: rdata=%h resp=%b gid=%0d, required 12345678 10 2",
               rsp_rdata, rsp_resp, grant_id);
    end
  endtask

  task automatic test_spurious();
    inject_spur = 1'b1;
    @(negedge aclk);
    post(1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'b0101, '0, 2'b00, 2);
    wait_drain("spurious");
    inject_spur = 1'b0;
    total++;
    if (rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b00) begin
      bad++;
      $display("FAIL spurious_rdata_kept: rdata=%h resp=%b, required 12345678 00", rsp_rdata, rsp_resp);
    end
  endtask

  task automatic test_reset_midwait();
    int n = 0;
    @(negedge aclk);
    post(0, 1'b1, 32'h0000_0500, 32'h5555_5555, 4'hF, '0, 2'b00, 30);
    while (!pend && n < 20) begin
      @(negedge aclk);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL midwait_issue_timeout: no request after %0d cycles, required one", n);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    total++;
    if ({req_done, rsp_rdata, rsp_resp, grant_id, busy, m_wr_req, m_wr_addr, m_wr_data,
         m_wr_strb, m_rd_req, m_rd_addr} !== '0) begin
      bad++;
      $display("FAIL midwait_reset_outputs: busy=%b gid=%0d rdata=%h waddr=%h, required all zero",
               busy, grant_id, rsp_rdata, m_wr_addr);
    end
    req_valid = '0;
    set_req(3, 1'b0, 32'h0000_0600, '0, '0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    push_exp(3, 1'b0, 32'h0000_0600, '0, '0, 32'h7777_8888, 2'b00, 1);
    @(posedge aclk);
    #1;
    total++;
    if (m_rd_req !== 1'b1 || m_wr_req !== 1'b0 || grant_id !== 2'd3 || m_rd_addr !== 32'h0000_0600) begin
      bad++;
      $display("FAIL post_reset_grant: rd_req=%b wr_req=%b gid=%0d addr=%h, required 1 0 3 00000600",
               m_rd_req, m_wr_req, grant_id, m_rd_addr);
    end
    wait_drain("post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_all_four();
    test_single_write();
    test_wrap();
    test_read_slverr();
    test_spurious();
    test_reset_midwait();
    repeat (3) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_arbiter.md
Name: axi_lite_master_arbiter

Overview:
- Shares one axi_lite_master user interface between NUM_REQ local requesters, e.g. config, DMA-descriptor and debug agents.
- Round-robin arbitration; exactly one transaction (read or write) outstanding at a time.
- Issues a one-cycle wr_req/rd_req pulse to the master, waits for wr_done/rd_done, then returns response and data to the granted requester.
- Sits between local control logic and the AXI-Lite master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, address width; matches the master.
- DATA_WIDTH, 32, data width; multiple of 8; matches the master.
- ID_WIDTH, 2, width of grant_id; must be >= clog2(NUM_REQ).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_done.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data of the last completed read.
- rsp_resp  out  2  BRESP/RRESP of the last completed transaction.
- grant_id  out  ID_WIDTH  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- m_wr_req  out  1  to master wr_req.
- m_wr_addr  out  ADDR_WIDTH  to master wr_addr.
- m_wr_data  out  DATA_WIDTH  to master wr_data.
- m_wr_strb  out  DATA_WIDTH/8  to master wr_strb.
- m_wr_done  in  1  from master wr_done.
- m_wr_resp  in  2  from master wr_resp.
- m_rd_req  out  1  to master rd_req.
- m_rd_addr  out  ADDR_WIDTH  to master rd_addr.
- m_rd_data  in  DATA_WIDTH  from master rd_data.
- m_rd_done  in  1  from master rd_done.
- m_rd_resp  in  2  from master rd_resp.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE; all outputs 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - An in-flight master transaction is abandoned; the whole subsystem shares aresetn.
- FSM states IDLE, ISSUE, WAIT, DONE; outputs are registered or decoded from state (Moore).
- IDLE:
  - If any req_valid is high, select the winner by searching indices last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register grant_id, last_grant and op = req_write[winner].
  - Latch the winner's addr/wdata/wstrb into m_wr_addr/m_wr_data/m_wr_strb for a write, or m_rd_addr for a read.
  - Go to ISSUE. With no requests, stay in IDLE.
- ISSUE:
  - m_wr_req (write) or m_rd_req (read) is high for exactly this one cycle; the other req stays 0.
  - Next state WAIT.
  - Latency: req_valid sampled at edge T gives the master request high in cycle T+1.
- WAIT:
  - Hold all m_* address/data fields stable.
  - Write: on m_wr_done, register rsp_resp = m_wr_resp; rsp_rdata unchanged; go to DONE.
  - Read: on m_rd_done, register rsp_rdata = m_rd_data and rsp_resp = m_rd_resp; go to DONE.
  - A done of the wrong type (m_rd_done during a write, or vice versa) is ignored.
  - No timeout; WAIT is held indefinitely.
- DONE:
  - req_done[grant_id] = 1 for this single cycle; rsp_* valid.
  - Next state IDLE.
  - A requester must deassert req_valid at the edge where it samples req_done high, or issue a new request only after that edge. A still-high req_valid in IDLE is treated as a new request.
- Outputs between transactions:
  - rsp_rdata, rsp_resp and grant_id hold their values until the next completion or grant.
  - m_* address/data fields hold until the next grant.
- Simultaneous requests: only one is granted per IDLE pass. Losers stay pending and need no re-request.
- Fairness: a continuously requesting agent waits at most NUM_REQ-1 transactions.
- Write and read requests share one arbitration queue; there is no read/write priority.
- Inputs of non-granted requesters and changes after grant have no effect on the current transaction.

Test Plan:
- Req0 write addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF at edge T → m_wr_req high only in cycle T+1 with those values. Slave BRESP=OKAY → req_done[0] one cycle after m_wr_done, rsp_resp=0, busy low afterward.
- All four request at once (0,2 writes; 1,3 reads), held until done → grant order 0,1,2,3; each req_done is one-hot, and only one m_*_req pulse per transaction.
- last_grant=1, req0 and req1 pending → requester 0 granted (search from 2 wraps to 0), then requester 1.
- Req2 read addr 0x40, slave returns 0x1234_5678 with RRESP=SLVERR → rsp_rdata=0x1234_5678, rsp_resp=2'b10, req_done[2] pulses, grant_id=2.
- During a write WAIT, inject a spurious m_rd_done → ignored, state stays WAIT; completes on m_wr_done.
- Assert aresetn low during WAIT → all outputs 0 immediately. After release, a pending req3 is granted only after req0..req2, which are idle, are skipped; requester 3 is granted first cycle.
